trap_squash_ctrl: RTL
=====================

Name: trap_squash_ctrl

Overview:
Commit-stage sequencer between the ROB commit logic, FTQ, CSR file and the pipeline-wide squash bus.
- On an exception at the commit head: stalls commit, reads the fetch-block start address from the FTQ, forms EPC, writes the trap into the CSRs and squashes to the trap vector.
- On a mispredicted branch at the commit head: issues the branch redirect squash.
- After every squash, holds commit for a fixed drain window.

Parameters:
XLEN, 64, data/address width
FTQ_IDX_W, 4, FTQ index width
FTQ_OFS_W, 5, byte offset of an instruction within its fetch block
CAUSE_W, 6, trap cause width (MSB = interrupt flag)
DRAIN_CYCLES, 2, cycles commit stays stalled after a squash (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
i_except_vld  in  1  oldest exception reached commit head (level, sampled in IDLE only)
i_except_cause  in  CAUSE_W  exception cause
i_except_tval  in  XLEN  trap value
i_except_ftq_idx  in  FTQ_IDX_W  FTQ entry of the faulting instruction
i_except_ftq_ofs  in  FTQ_OFS_W  offset of the faulting instruction
i_mispred_vld  in  1  oldest mispredicted branch reached commit head
i_mispred_npc  in  XLEN  correct next PC
i_mispred_taken  in  1  resolved branch direction
o_ftq_rd_idx  out  FTQ_IDX_W  FTQ read index (combinational read)
i_ftq_rd_addr  in  XLEN  fetch-block start address, valid in the same cycle
i_csr_tvec  in  XLEN  current mtvec
o_csr_trap_vld  out  1  one-cycle CSR trap write strobe
o_csr_epc  out  XLEN  mepc value
o_csr_cause  out  CAUSE_W  mcause value
o_csr_tval  out  XLEN  mtval value
o_commit_stall  out  1  block ROB commit
o_squash_vld  out  1  one-cycle squash pulse
o_squash_pc  out  XLEN  redirect PC
o_squash_dueToBranch  out  1  squash is a branch redirect
o_squash_taken  out  1  branch direction of the redirect
o_busy  out  1  FSM not in IDLE

Behaviour:
- States: IDLE, READ, TRAP, DRAIN. rst low (asynchronous) forces IDLE, clears the drain counter and drives every output to 0, including o_ftq_rd_idx and all data outputs. Reset mid-sequence aborts the sequence; no CSR write or squash follows.
- IDLE:
  - i_except_vld: latch cause, tval, ftq_idx and ftq_ofs; go to READ.
  - else i_mispred_vld: next cycle o_squash_vld=1, o_squash_pc=i_mispred_npc, o_squash_dueToBranch=1, o_squash_taken=i_mispred_taken; go to DRAIN.
  - Both high in the same cycle: exception wins, mispred is dropped.
- READ:
  - o_ftq_rd_idx = latched idx (held at the last value in all other states).
  - Register epc = i_ftq_rd_addr + zero-extended ofs, modulo 2^XLEN.
  - Go to TRAP.
- TRAP (entered one cycle after READ): in the cycle after entry, drive exactly one pulse of each:
  - o_csr_trap_vld=1, with o_csr_epc/o_csr_cause/o_csr_tval.
  - o_squash_vld=1, o_squash_pc={i_csr_tvec[XLEN-1:2],2'b00} (tvec sampled in TRAP), o_squash_dueToBranch=0, o_squash_taken=0.
  - Then go to DRAIN.
- Latency: exception detect at cycle 0 → CSR write and squash pulse at cycle 3. Mispred detect at cycle 0 → squash pulse at cycle 1.
- DRAIN: counter loads DRAIN_CYCLES on entry and decrements each cycle; at 0 return to IDLE. Exactly DRAIN_CYCLES cycles are spent in DRAIN.
- o_commit_stall and o_busy are registered; both are 1 from the cycle after detection until IDLE is re-entered. In the detection cycle the ROB suppresses commit itself.
- i_except_vld and i_mispred_vld are ignored outside IDLE. A request still high when IDLE is re-entered is taken as a new event.
- Pulse outputs are 0 in every cycle other than those specified. Data outputs hold their last values.

Optional Feature:
TRAP_INTERRUPT_EN
- Adds ports i_irq_vld (1), i_irq_cause (CAUSE_W-1) and i_irq_epc (XLEN, next PC to commit).
- In IDLE, with no exception and no mispred, i_irq_vld goes directly to TRAP, skipping READ.
- Values on that path: cause={1'b1,i_irq_cause}, tval=0, epc=i_irq_epc.
- Vectored mode: if i_csr_tvec[1:0]==2'b01, squash pc = base + 4*i_irq_cause.
- Priority: exception > mispred > interrupt.
- Without the macro, the ports are absent and interrupts are never taken.

Test Plan:
- except cause=2, ftq_idx=3, ofs=6, FTQ[3]=0x8000_1000, tvec=0x8000_0101 → cycle 3: csr_trap_vld=1, epc=0x8000_1006, cause=2; squash_pc=0x8000_0100, dueToBranch=0.
- mispred npc=0x8000_2040, taken=1 → cycle 1: squash_vld=1, pc=0x8000_2040, dueToBranch=1, taken=1; stall high for exactly 2 cycles after the pulse.
- except and mispred in the same cycle → only the trap sequence runs; exactly one squash pulse, dueToBranch=0.
- FTQ addr 0xFFFF_FFFF_FFFF_FFFC, ofs=8 → epc wraps to 0x4.
- rst low during TRAP → all outputs 0 at once; no csr_trap_vld; next mispred is handled normally.
- TRAP_INTERRUPT_EN: irq cause=7, tvec=0x1001, epc=0x5000 → cause MSB=1, squash_pc=0x101C, epc=0x5000; irq held low while an exception is pending.

Source files
------------

// File: rtl/trap_squash_ctrl_if.sv
// Bus bundle between the commit-stage trap/redirect sequencer and its ROB/FTQ/CSR/squash neighbours.
// The interrupt signals exist only when TRAP_INTERRUPT_EN is defined.
interface trap_squash_ctrl_if #(
    parameter int XLEN      = 64,
    parameter int FTQ_IDX_W = 4,
    parameter int FTQ_OFS_W = 5,
    parameter int CAUSE_W   = 6
);
    logic                 i_except_vld;
    logic [CAUSE_W-1:0]   i_except_cause;
    logic [XLEN-1:0]      i_except_tval;
    logic [FTQ_IDX_W-1:0] i_except_ftq_idx;
    logic [FTQ_OFS_W-1:0] i_except_ftq_ofs;
    logic                 i_mispred_vld;
    logic [XLEN-1:0]      i_mispred_npc;
    logic                 i_mispred_taken;
    logic [FTQ_IDX_W-1:0] o_ftq_rd_idx;
    logic [XLEN-1:0]      i_ftq_rd_addr;
    logic [XLEN-1:0]      i_csr_tvec;
    logic                 o_csr_trap_vld;
    logic [XLEN-1:0]      o_csr_epc;
    logic [CAUSE_W-1:0]   o_csr_cause;
    logic [XLEN-1:0]      o_csr_tval;
    logic                 o_commit_stall;
    logic                 o_squash_vld;
    logic [XLEN-1:0]      o_squash_pc;
    logic                 o_squash_dueToBranch;
    logic                 o_squash_taken;
    logic                 o_busy;
`ifdef TRAP_INTERRUPT_EN
    logic                 i_irq_vld;
    logic [CAUSE_W-2:0]   i_irq_cause;
    logic [XLEN-1:0]      i_irq_epc;
`endif

    modport master (
        output i_except_vld, i_except_cause, i_except_tval, i_except_ftq_idx, i_except_ftq_ofs,
        output i_mispred_vld, i_mispred_npc, i_mispred_taken, i_ftq_rd_addr, i_csr_tvec,
`ifdef TRAP_INTERRUPT_EN
        output i_irq_vld, i_irq_cause, i_irq_epc,
`endif
        input  o_ftq_rd_idx, o_csr_trap_vld, o_csr_epc, o_csr_cause, o_csr_tval,
        input  o_commit_stall, o_squash_vld, o_squash_pc, o_squash_dueToBranch, o_squash_taken, o_busy
    );

    modport slave (
        input  i_except_vld, i_except_cause, i_except_tval, i_except_ftq_idx, i_except_ftq_ofs,
        input  i_mispred_vld, i_mispred_npc, i_mispred_taken, i_ftq_rd_addr, i_csr_tvec,
`ifdef TRAP_INTERRUPT_EN
        input  i_irq_vld, i_irq_cause, i_irq_epc,
`endif
        output o_ftq_rd_idx, o_csr_trap_vld, o_csr_epc, o_csr_cause, o_csr_tval,
        output o_commit_stall, o_squash_vld, o_squash_pc, o_squash_dueToBranch, o_squash_taken, o_busy
    );
endinterface

// File: rtl/trap_squash_ctrl.sv
// Commit-stage sequencer: exception -> FTQ read -> CSR trap write + squash, branch redirect squash, drain.
// Define TRAP_INTERRUPT_EN to add the direct interrupt-to-TRAP path.
//   state | meaning
//   IDLE  | waiting for exception / mispredict (/ interrupt)
//   READ  | FTQ read of faulting fetch block, EPC formed
//   TRAP  | CSR write and squash-to-vector issued at exit
//   DRAIN | commit held for DRAIN_CYCLES after a squash
module trap_squash_ctrl #(
    parameter int XLEN         = 64,
    parameter int FTQ_IDX_W    = 4,
    parameter int FTQ_OFS_W    = 5,
    parameter int CAUSE_W      = 6,
    parameter int DRAIN_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    trap_squash_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_TRAP, S_DRAIN} state_t;

    localparam logic [3:0]      LP_DRAIN = 4'(DRAIN_CYCLES);
    localparam logic [XLEN-1:0] LP_ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

    state_t               r_state, w_nxt_state;
    logic [3:0]           r_drain_cnt;
    logic [CAUSE_W-1:0]   r_cause;
    logic [XLEN-1:0]      r_tval;
    logic [FTQ_IDX_W-1:0] r_ftq_idx;
    logic [FTQ_OFS_W-1:0] r_ofs;
    logic [XLEN-1:0]      r_epc;
    logic                 r_csr_trap_vld;
    logic [XLEN-1:0]      r_csr_epc;
    logic [CAUSE_W-1:0]   r_csr_cause;
    logic [XLEN-1:0]      r_csr_tval;
    logic                 r_squash_vld;
    logic [XLEN-1:0]      r_squash_pc;
    logic                 r_squash_br;
    logic                 r_squash_taken;
    logic                 r_stall;
    logic                 r_busy;
    logic [XLEN-1:0]      w_epc_sum;
    logic [XLEN-1:0]      w_trap_pc;
`ifdef TRAP_INTERRUPT_EN
    logic                 r_irq;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_epc_sum   = bus.i_ftq_rd_addr + XLEN'(r_ofs);
        w_trap_pc   = bus.i_csr_tvec & LP_ALIGN;
`ifdef TRAP_INTERRUPT_EN
        // Vectored mode only applies to interrupts; exceptions always go to the base.
        if (r_irq && (bus.i_csr_tvec[1:0] == 2'b01))
            w_trap_pc = (bus.i_csr_tvec & LP_ALIGN) + (XLEN'(r_cause[CAUSE_W-2:0]) << 2);
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_except_vld)       w_nxt_state = S_READ;
                else if (bus.i_mispred_vld) w_nxt_state = S_DRAIN;
`ifdef TRAP_INTERRUPT_EN
                else if (bus.i_irq_vld)     w_nxt_state = S_TRAP;
`endif
            end
            S_READ:  w_nxt_state = S_TRAP;
            S_TRAP:  w_nxt_state = S_DRAIN;
            S_DRAIN: if (r_drain_cnt <= 4'd1) w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_drain_cnt    <= '0;
            r_cause        <= '0;
            r_tval         <= '0;
            r_ftq_idx      <= '0;
            r_ofs          <= '0;
            r_epc          <= '0;
            r_csr_trap_vld <= 1'b0;
            r_csr_epc      <= '0;
            r_csr_cause    <= '0;
            r_csr_tval     <= '0;
            r_squash_vld   <= 1'b0;
            r_squash_pc    <= '0;
            r_squash_br    <= 1'b0;
            r_squash_taken <= 1'b0;
            r_stall        <= 1'b0;
            r_busy         <= 1'b0;
`ifdef TRAP_INTERRUPT_EN
            r_irq          <= 1'b0;
`endif
        end else begin
            r_state        <= w_nxt_state;
            r_csr_trap_vld <= 1'b0;
            r_squash_vld   <= 1'b0;
            r_stall        <= (w_nxt_state != S_IDLE);
            r_busy         <= (w_nxt_state != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (bus.i_except_vld) begin
                        r_cause   <= bus.i_except_cause;
                        r_tval    <= bus.i_except_tval;
                        r_ftq_idx <= bus.i_except_ftq_idx;
                        r_ofs     <= bus.i_except_ftq_ofs;
`ifdef TRAP_INTERRUPT_EN
                        r_irq     <= 1'b0;
`endif
                    end else if (bus.i_mispred_vld) begin
                        r_squash_vld   <= 1'b1;
                        r_squash_pc    <= bus.i_mispred_npc;
                        r_squash_br    <= 1'b1;
                        r_squash_taken <= bus.i_mispred_taken;
                    end
`ifdef TRAP_INTERRUPT_EN
                    else if (bus.i_irq_vld) begin
                        r_cause <= {1'b1, bus.i_irq_cause};
                        r_tval  <= '0;
                        r_epc   <= bus.i_irq_epc;
                        r_irq   <= 1'b1;
                    end
`endif
                end
                S_READ: r_epc <= w_epc_sum;
                S_TRAP: begin
                    r_csr_trap_vld <= 1'b1;
                    r_csr_epc      <= r_epc;
                    r_csr_cause    <= r_cause;
                    r_csr_tval     <= r_tval;
                    r_squash_vld   <= 1'b1;
                    r_squash_pc    <= w_trap_pc;
                    r_squash_br    <= 1'b0;
                    r_squash_taken <= 1'b0;
                end
                S_DRAIN: r_drain_cnt <= r_drain_cnt - 4'd1;
                default: ;
            endcase
            if ((w_nxt_state == S_DRAIN) && (r_state != S_DRAIN))
                r_drain_cnt <= LP_DRAIN;
        end
    end

    assign bus.o_ftq_rd_idx         = r_ftq_idx;
    assign bus.o_csr_trap_vld       = r_csr_trap_vld;
    assign bus.o_csr_epc            = r_csr_epc;
    assign bus.o_csr_cause          = r_csr_cause;
    assign bus.o_csr_tval           = r_csr_tval;
    assign bus.o_commit_stall       = r_stall;
    assign bus.o_squash_vld         = r_squash_vld;
    assign bus.o_squash_pc          = r_squash_pc;
    assign bus.o_squash_dueToBranch = r_squash_br;
    assign bus.o_squash_taken       = r_squash_taken;
    assign bus.o_busy               = r_busy;
endmodule
